// File: rtl/recfn_wb_pkg.sv
// Shared widths and the stage-entry type for the narrowed-result writeback path.
package recfn_wb_pkg;
    localparam int EXP_W        = 9;
    localparam int SIG_W        = 23;
    localparam int REC_W        = 1 + EXP_W + SIG_W;
    localparam int FLEN         = 64;
    localparam int MIN_NORM_EXP = 130;
    localparam int EXP_BIAS_ADJ = 129;
    localparam logic [31:0] NAN_BOX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [FLEN-1:0] data;
        logic [4:0]      rd;
    } wb_entry_t;
endpackage

// File: rtl/recfn32_to_fn32.sv
// Combinational recoded-single (33 bit) to IEEE binary32 conversion.
module recfn32_to_fn32
    import recfn_wb_pkg::*;
(
    input  logic [REC_W-1:0] rec,
    output logic [31:0]      ieee
);
    logic             sign;
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] sig;
    logic [EXP_W-1:0] sub_dist;
    logic [4:0]       sub_shift;
    logic [SIG_W-1:0] sub_sig;
    logic [7:0]       norm_exp;
    logic [7:0]       exp8;
    logic [SIG_W-1:0] frac;

    assign sign      = rec[REC_W-1];
    assign e         = rec[REC_W-2:SIG_W];
    assign sig       = rec[SIG_W-1:0];
    // Distances beyond 24 shift every significand bit out; clamp so the shifter stays 5 bits.
    assign sub_dist  = EXP_W'(MIN_NORM_EXP) - e;
    assign sub_shift = (sub_dist > 9'd24) ? 5'd24 : sub_dist[4:0];
    assign sub_sig   = SIG_W'({1'b1, sig} >> sub_shift);
    assign norm_exp  = 8'(e - EXP_W'(EXP_BIAS_ADJ));

    always_comb begin
        exp8 = norm_exp;
        frac = sig;
        if (e[8:6] == 3'b000) begin
            exp8 = '0;
            frac = '0;
        end else if (e[8:6] == 3'b110) begin
            exp8 = 8'hFF;
            frac = '0;
        end else if (e[8:6] == 3'b111) begin
            exp8 = 8'hFF;
            frac = sig;
        end else if (e < EXP_W'(MIN_NORM_EXP)) begin
            exp8 = '0;
            frac = sub_sig;
        end
    end

    assign ieee = {sign, exp8, frac};
endmodule

// File: rtl/recfn_narrow_writeback.sv
// Writeback stage for narrowed FP results: convert, NaN-box, buffer in a main/skid pair,
// and accumulate sticky exception flags.
module recfn_narrow_writeback
    import recfn_wb_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [REC_W-1:0] io_in_bits_data,
    input  logic [4:0]       io_in_bits_exc,
    input  logic [4:0]       io_in_bits_rd,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [FLEN-1:0]  io_out_bits_data,
    output logic [4:0]       io_out_bits_rd,
    input  logic             io_flush,
    input  logic             io_fflags_clear,
    output logic [4:0]       io_fflags
);
    logic [31:0] ieee_p0;
    wb_entry_t   entry_p0;
    logic        accept;
    logic        drain;
    wb_entry_t   m_p1;
    wb_entry_t   k_p1;
    logic        vld_m_p1;
    logic        vld_k_p1;
    logic [4:0]  fflags;

    recfn32_to_fn32 u_conv (
        .rec  (io_in_bits_data),
        .ieee (ieee_p0)
    );

    assign entry_p0    = '{data: {NAN_BOX, ieee_p0}, rd: io_in_bits_rd};
    // Ready depends only on skid occupancy, so the output handshake never reaches it.
    assign io_in_ready = ~vld_k_p1;
    assign accept      = io_in_valid & io_in_ready;
    assign drain       = vld_m_p1 & io_out_ready;

    // p0 -> p1: occupancy of the main and skid registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_m_p1 <= 1'b0;
            vld_k_p1 <= 1'b0;
        end else if (io_flush) begin
            vld_m_p1 <= 1'b0;
            vld_k_p1 <= 1'b0;
        end else if (drain || !vld_m_p1) begin
            vld_m_p1 <= vld_k_p1 | accept;
            vld_k_p1 <= vld_k_p1 & accept;
        end else if (accept) begin
            vld_k_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_p1 <= '0;
        end else if (!io_flush && (drain || !vld_m_p1)) begin
            if (vld_k_p1)
                m_p1 <= k_p1;
            else if (accept)
                m_p1 <= entry_p0;
        end
    end

    always_ff @(posedge clock) begin
        if (accept && (vld_k_p1 || (vld_m_p1 && !drain)))
            k_p1 <= entry_p0;
    end

    // Clear takes effect before the OR, and flushed beats still report their flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            fflags <= '0;
        else if (io_fflags_clear)
            fflags <= accept ? io_in_bits_exc : 5'b0;
        else if (accept)
            fflags <= fflags | io_in_bits_exc;
    end

    no_accept_when_skid_full: assert property (@(posedge clock) disable iff (reset)
        !(accept && vld_k_p1));

    assign io_out_valid     = vld_m_p1;
    assign io_out_bits_data = m_p1.data;
    assign io_out_bits_rd   = m_p1.rd;
    assign io_fflags        = fflags;
endmodule

// File: tb/tb_recfn_narrow_writeback.sv
// Self-checking bench for recfn_narrow_writeback: directed spec cases plus randomized traffic
// against a queue-based reference model.
module tb_recfn_narrow_writeback;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_data;
    logic [4:0]  in_exc;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        flush;
    logic        fclear;
    logic [4:0]  fflags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
    } exp_t;
    exp_t       q[$];
    logic [4:0] mf;

    recfn_narrow_writeback dut (
        .clock            (clock),
        .reset            (reset),
        .io_in_valid      (in_valid),
        .io_in_ready      (in_ready),
        .io_in_bits_data  (in_data),
        .io_in_bits_exc   (in_exc),
        .io_in_bits_rd    (in_rd),
        .io_out_valid     (out_valid),
        .io_out_ready     (out_ready),
        .io_out_bits_data (out_data),
        .io_out_bits_rd   (out_rd),
        .io_flush         (flush),
        .io_fflags_clear  (fclear),
        .io_fflags        (fflags)
    );

    always #5 clock = ~clock;

    // Value-level reference: classify by exponent range, subnormals via integer division.
    function automatic logic [31:0] ref_conv(input logic [32:0] r);
        int          e;
        longint      mag;
        logic [7:0]  ex;
        logic [22:0] fr;
        e = int'(r[31:23]);
        if (e < 64) begin
            ex = 8'h00; fr = 23'h0;
        end else if (e >= 448) begin
            ex = 8'hFF; fr = r[22:0];
        end else if (e >= 384) begin
            ex = 8'hFF; fr = 23'h0;
        end else if (e < 130) begin
            ex  = 8'h00;
            mag = (longint'(1) << 23) + longint'(r[22:0]);
            if (130 - e > 24) fr = 23'h0;
            else fr = 23'(mag / (longint'(1) << (130 - e)));
        end else begin
            ex = 8'((e - 129) % 256); fr = r[22:0];
        end
        return {r[32], ex, fr};
    endfunction

    function automatic logic [32:0] rand_rec();
        logic [8:0] e;
        case ($urandom_range(0, 4))
            0: e = 9'($urandom_range(0, 63));
            1: e = 9'($urandom_range(64, 129));
            2: e = 9'($urandom_range(130, 383));
            3: e = 9'($urandom_range(384, 447));
            default: e = 9'($urandom_range(448, 511));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic drive(input logic v, input logic [32:0] d, input logic [4:0] x,
                         input logic [4:0] r, input logic ordy, input logic fl, input logic cl);
        in_valid  = v;
        in_data   = d;
        in_exc    = x;
        in_rd     = r;
        out_ready = ordy;
        flush     = fl;
        fclear    = cl;
    endtask

    // Advance the reference model by one cycle from the current inputs, then clock.
    task automatic tick();
        bit   acc, drn;
        exp_t e;
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        if (fclear) mf = acc ? in_exc : 5'b0;
        else if (acc) mf = mf | in_exc;
        if (flush) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                e.data = {32'hFFFF_FFFF, ref_conv(in_data)};
                e.rd   = in_rd;
                q.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, '0, '0, '0, 0, 0, 0);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_out_rd: got %0d want 0", out_rd); end
        checks++; if (fflags !== 5'b0) begin errors++; $display("FAIL reset_fflags: got %b want 0", fflags); end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        q.delete();
        mf = '0;
    endtask

    task automatic test_normal();
        drive(1, 33'h0_8000_0000, 5'b0, 5'd3, 1, 0, 0);
        tick();
        drive(0, '0, '0, '0, 1, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL normal_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 64'hFFFFFFFF_3F800000) begin errors++; $display("FAIL normal_data: got %h want FFFFFFFF3F800000", out_data); end
        checks++; if (out_rd !== 5'd3) begin errors++; $display("FAIL normal_rd: got %0d want 3", out_rd); end
        tick();
    endtask

    task automatic test_specials();
        logic [32:0] ins  [3];
        logic [63:0] outs [3];
        ins  = '{33'h0_C000_0000, 33'h0_E040_0000, 33'h1_0000_0000};
        outs = '{64'hFFFFFFFF_7F800000, 64'hFFFFFFFF_7FC00000, 64'hFFFFFFFF_80000000};
        for (int i = 0; i < 3; i++) begin
            drive(1, ins[i], 5'b0, 5'(i + 10), 1, 0, 0);
            tick();
            drive(0, '0, '0, '0, 1, 0, 0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== outs[i]) begin
                errors++; $display("FAIL special_%0d: got v=%b %h want v=1 %h", i, out_valid, out_data, outs[i]);
            end
            tick();
        end
    endtask

    task automatic test_subnormal();
        drive(1, 33'h0_3580_0000, 5'b00011, 5'd7, 1, 0, 0);
        tick();
        drive(0, '0, '0, '0, 1, 0, 0);
        checks++; if (out_data !== 64'hFFFFFFFF_00000001) begin errors++; $display("FAIL subnormal_data: got %h want FFFFFFFF00000001", out_data); end
        checks++; if (fflags !== 5'b00011) begin errors++; $display("FAIL subnormal_fflags: got %b want 00011", fflags); end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [32:0] d3;
        int          got[$];
        bit          pending;
        d3 = rand_rec();
        drive(1, rand_rec(), 5'b0, 5'd1, 0, 0, 0);
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b want 1", in_ready); end
        drive(1, rand_rec(), 5'b0, 5'd2, 0, 0, 0);
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_two: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd1) begin errors++; $display("FAIL bp_head: got v=%b rd=%0d want v=1 rd=1", out_valid, out_rd); end
        drive(1, d3, 5'b0, 5'd3, 0, 0, 0);
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold: got %b want 0", in_ready); end
        checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL bp_hold_rd: got %0d want 1", out_rd); end
        pending = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (out_valid) got.push_back(int'(out_rd));
            in_valid = pending;
            if (pending && in_ready) pending = 1'b0;
            tick();
        end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count: got %0d beats want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++; if (got[i] != i + 1) begin errors++; $display("FAIL bp_order_%0d: got rd %0d want %0d", i, got[i], i + 1); end
        end
    endtask

    task automatic test_fflags();
        drive(0, '0, '0, '0, 1, 0, 1);
        tick();
        checks++; if (fflags !== 5'b0) begin errors++; $display("FAIL ff_clear: got %b want 00000", fflags); end
        drive(1, rand_rec(), 5'b10000, 5'd4, 1, 0, 0);
        tick();
        checks++; if (fflags !== 5'b10000) begin errors++; $display("FAIL ff_accum: got %b want 10000", fflags); end
        drive(1, rand_rec(), 5'b00001, 5'd5, 1, 0, 1);
        tick();
        checks++; if (fflags !== 5'b00001) begin errors++; $display("FAIL ff_clear_accept: got %b want 00001", fflags); end
        drive(0, '0, '0, '0, 1, 0, 0);
        tick();
    endtask

    task automatic test_flush();
        drive(1, rand_rec(), 5'b0, 5'd8, 0, 0, 0);
        tick();
        drive(1, rand_rec(), 5'b0, 5'd9, 0, 0, 0);
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_full: got rdy=%b v=%b want 0 1", in_ready, out_valid); end
        drive(0, '0, '0, '0, 0, 1, 0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        drive(1, rand_rec(), 5'b00100, 5'd11, 1, 1, 0);
        tick();
        drive(0, '0, '0, '0, 1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b want 0", out_valid); end
        checks++; if (fflags !== mf || fflags[2] !== 1'b1) begin errors++; $display("FAIL flush_fflags: got %b want %b", fflags, mf); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, out_valid, q.size() > 0); end
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, in_ready, q.size() < 2); end
            checks++; if (fflags !== mf) begin errors++; $display("FAIL rnd_fflags@%0d: got %b want %b", n, fflags, mf); end
            if (q.size() > 0) begin
                checks++;
                if (out_data !== q[0].data || out_rd !== q[0].rd) begin
                    errors++; $display("FAIL rnd_data@%0d: got %h/%0d want %h/%0d", n, out_data, out_rd, q[0].data, q[0].rd);
                end
            end
            drive($urandom_range(0, 3) != 0, rand_rec(), 5'($urandom), 5'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
            tick();
        end
        drive(0, '0, '0, '0, 1, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_async_reset();
        drive(1, 33'h0_8000_0000, 5'b01000, 5'd21, 0, 0, 0);
        tick();
        drive(1, 33'h0_C000_0000, 5'b00010, 5'd22, 0, 0, 0);
        tick();
        drive(0, '0, '0, '0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b want 1", in_ready); end
        checks++; if (fflags !== 5'b0) begin errors++; $display("FAIL areset_fflags: got %b want 0", fflags); end
        checks++; if (out_data !== 64'h0 || out_rd !== 5'd0) begin errors++; $display("FAIL areset_bits: got %h/%0d want 0/0", out_data, out_rd); end
        q.delete();
        mf = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_after: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_subnormal();
        test_back_pressure();
        test_fflags();
        test_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
